fifo_push_arbiter: RTL and testbench

//  Shares the single 8-bit push port of one fifo instance among NREQ requesters.

---
 rtl/fifo_push_arbiter.sv | 104 ++++++++++
 tb/tb_fifo_push_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_push_arbiter.sv
// rtl/fifo_push_arbiter.sv - round-robin arbiter sharing one fifo push port, with reserved-occupancy tracking
module fifo_push_arbiter #(
   parameter int NREQ  = 4,
   parameter int DEPTH = 16,
   parameter int DW    = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NREQ-1:0]              req_valid,
   input  logic [NREQ*DW-1:0]           req_data,
   output logic [NREQ-1:0]              req_ready,
   output logic                         fifo_push,
   output logic [DW-1:0]                fifo_data_in,
   input  logic                         fifo_pop,
   input  logic                         fifo_empty,
   input  logic                         fifo_full,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         err_overflow,
   output logic                         err_count
);

   localparam int LW = $clog2(DEPTH + 1);
   localparam int IW = $clog2(NREQ);
   localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
   localparam logic [IW-1:0] LAST_IDX   = IW'(NREQ - 1);

   // Index of the requester sitting 'offset' positions after 'base' in the ring.
   function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int offset);
      int sum;
      sum = (int'(base) + offset) % NREQ;
      return IW'(sum);
   endfunction

   logic [IW-1:0] last_grant;
   logic [IW-1:0] cand;
   logic [IW-1:0] grant_idx;
   logic          grant_any;
   logic [NREQ-1:0] grant;
   logic          space;
   logic          inc;
   logic          dec;
   logic [LW-1:0] level_next;

   // A slot is free while reserved occupancy is below capacity; in-flight pushes are already counted.
   assign space = (level < FULL_LEVEL);

   // Round-robin search starting just after the last granted requester; first valid one wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      cand      = '0;
      if (!rst && space) begin
         for (int k = 1; k <= NREQ; k++) begin
            cand = rr_index(last_grant, k);
            if (!grant_any && req_valid[cand]) begin
               grant_any       = 1'b1;
               grant_idx       = cand;
               grant[cand]     = 1'b1;
            end
         end
      end
   end

   assign req_ready = grant;
   assign inc       = grant_any;
   assign dec       = fifo_pop & ~fifo_empty;

   // Occupancy update; a pop against an empty count is clamped at zero (and flagged below).
   always_comb begin
      level_next = level;
      case ({inc, dec})
         2'b10:   level_next = level + LW'(1);
         2'b01:   level_next = (level == '0) ? '0 : level - LW'(1);
         default: level_next = level;
      endcase
   end

   // Registered push path, round-robin pointer, occupancy and sticky error flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         level        <= '0;
         fifo_push    <= 1'b0;
         fifo_data_in <= '0;
         err_overflow <= 1'b0;
         err_count    <= 1'b0;
         last_grant   <= LAST_IDX;
      end else begin
         fifo_push <= grant_any;
         if (grant_any) begin
            fifo_data_in <= req_data[grant_idx*DW +: DW];
            last_grant   <= grant_idx;
         end
         level <= level_next;
         if (dec && (level == '0)) begin
            err_count <= 1'b1;
         end
         if (fifo_push && fifo_full) begin
            err_overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb/tb_fifo_push_arbiter.sv - self-checking bench for fifo_push_arbiter against a behavioural model
module tb_fifo_push_arbiter;

   localparam int NREQ  = 4;
   localparam int DEPTH = 16;
   localparam int DW    = 8;
   localparam int LW    = $clog2(DEPTH + 1);

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ*DW-1:0]   req_data;
   logic [NREQ-1:0]      req_ready;
   logic                 fifo_push;
   logic [DW-1:0]        fifo_data_in;
   logic                 fifo_pop;
   logic                 fifo_empty;
   logic                 fifo_full;
   logic [LW-1:0]        level;
   logic                 err_overflow;
   logic                 err_count;

   int errors = 0;
   int checks = 0;

   // behavioural model state
   int   m_level;
   int   m_last;
   logic m_push;
   logic [DW-1:0] m_data;
   logic m_erro;
   logic m_errc;
   int   f_cnt;
   bit   auto_flags = 1'b1;

   // values captured during the last cycle
   logic [NREQ-1:0] obs_ready;
   logic [NREQ-1:0] exp_ready;
   int              exp_g;

   fifo_push_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .DW(DW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .fifo_push(fifo_push), .fifo_data_in(fifo_data_in),
      .fifo_pop(fifo_pop), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
      .level(level), .err_overflow(err_overflow), .err_count(err_count)
   );

   always #5 clk = ~clk;

   // Grant the spec rule predicts: none without room, else first valid after the last grant.
   function automatic int model_grant();
      if (rst || m_level >= DEPTH) return -1;
      for (int k = 1; k <= NREQ; k++) begin
         if (req_valid[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
      end
      return -1;
   endfunction

   // One clock: sample combinational outputs at negedge, then advance model past posedge.
   task automatic advance();
      logic push_s;
      logic pop_s;
      @(negedge clk);
      obs_ready = req_ready;
      exp_g     = model_grant();
      exp_ready = (exp_g < 0) ? '0 : NREQ'(1 << exp_g);
      push_s    = fifo_push;
      pop_s     = fifo_pop & ~fifo_empty;
      @(posedge clk);
      #1;
      if (rst) begin
         m_level = 0; m_last = NREQ - 1; m_push = 1'b0; m_data = '0;
         m_erro = 1'b0; m_errc = 1'b0; f_cnt = 0;
      end else begin
         if (m_push && fifo_full) m_erro = 1'b1;
         if (pop_s && m_level == 0) m_errc = 1'b1;
         m_level = m_level + ((exp_g >= 0) ? 1 : 0) - (pop_s ? 1 : 0);
         if (m_level < 0) m_level = 0;
         m_push = (exp_g >= 0);
         if (exp_g >= 0) begin
            m_data = req_data[exp_g*DW +: DW];
            m_last = exp_g;
         end
         f_cnt = f_cnt + (push_s ? 1 : 0) - (pop_s ? 1 : 0);
      end
      if (auto_flags) begin
         fifo_empty = (f_cnt == 0);
         fifo_full  = (f_cnt >= DEPTH);
      end
   endtask

   task automatic reset_dut();
      rst = 1'b1; req_valid = '0; fifo_pop = 1'b0; auto_flags = 1'b1;
      advance();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = '1; req_data = $urandom; fifo_pop = 1'b0;
      for (int c = 0; c < 2; c++) begin
         advance();
         checks++; if (obs_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b want 0", obs_ready); end
         checks++; if (fifo_push !== 1'b0) begin errors++; $display("FAIL reset_push: got %b want 0", fifo_push); end
         checks++; if (level !== '0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
      end
      rst = 1'b0;
      advance();
      checks++; if (obs_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b want 0001", obs_ready); end
      checks++; if (fifo_data_in !== req_data[7:0]) begin errors++; $display("FAIL reset_first_data: got %h want %h", fifo_data_in, req_data[7:0]); end
   endtask

   task automatic test_round_robin();
      reset_dut();
      req_valid = 4'b1111;
      for (int c = 0; c < 8; c++) begin
         req_data = $urandom;
         advance();
         checks++; if (obs_ready !== NREQ'(1 << (c % NREQ))) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", c, obs_ready, NREQ'(1 << (c % NREQ))); end
         checks++; if (fifo_push !== 1'b1 || fifo_data_in !== req_data[(c % NREQ)*DW +: DW]) begin errors++; $display("FAIL rr_push%0d: got %b/%h want 1/%h", c, fifo_push, fifo_data_in, req_data[(c % NREQ)*DW +: DW]); end
      end
      checks++; if (level !== LW'(8)) begin errors++; $display("FAIL rr_level: got %0d want 8", level); end
   endtask

   task automatic test_full();
      int next_val;
      int pushes;
      reset_dut();
      next_val = 0; pushes = 0;
      req_valid = 4'b0100;
      for (int c = 0; c < 24; c++) begin
         req_data = '0;
         req_data[23:16] = DW'(next_val);
         advance();
         if (fifo_push) begin
            checks++; if (fifo_data_in !== DW'(pushes)) begin errors++; $display("FAIL full_data%0d: got %h want %h", pushes, fifo_data_in, DW'(pushes)); end
            pushes++;
         end
         if (obs_ready[2]) next_val++;
         if (next_val > 8'h13) req_valid = '0;
      end
      checks++; if (pushes != 16) begin errors++; $display("FAIL full_pushes: got %0d want 16", pushes); end
      checks++; if (level !== LW'(16)) begin errors++; $display("FAIL full_level: got %0d want 16", level); end
      checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL full_overflow: got %b want 0", err_overflow); end
      req_valid = 4'b0100;
      advance();
      checks++; if (obs_ready !== '0) begin errors++; $display("FAIL full_ready: got %b want 0", obs_ready); end
   endtask

   task automatic test_pop_at_full();
      req_valid = 4'b0100; req_data = '0; req_data[23:16] = 8'h10;
      fifo_pop = 1'b1; fifo_empty = 1'b0;
      advance();
      fifo_pop = 1'b0;
      checks++; if (obs_ready !== '0) begin errors++; $display("FAIL popfull_ready_t: got %b want 0", obs_ready); end
      checks++; if (level !== LW'(15)) begin errors++; $display("FAIL popfull_level_t1: got %0d want 15", level); end
      advance();
      checks++; if (obs_ready !== 4'b0100) begin errors++; $display("FAIL popfull_grant_t1: got %b want 0100", obs_ready); end
      checks++; if (fifo_push !== 1'b1 || fifo_data_in !== 8'h10) begin errors++; $display("FAIL popfull_push_t2: got %b/%h want 1/10", fifo_push, fifo_data_in); end
      checks++; if (level !== LW'(16)) begin errors++; $display("FAIL popfull_level_t2: got %0d want 16", level); end
      req_valid = '0;
      advance();
      checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL popfull_overflow: got %b want 0", err_overflow); end
   endtask

   task automatic test_simultaneous();
      reset_dut();
      req_valid = 4'b0010;
      for (int c = 0; c < 5; c++) begin
         req_data = $urandom;
         advance();
      end
      req_valid = '0;
      advance();
      checks++; if (level !== LW'(5)) begin errors++; $display("FAIL sim_prelevel: got %0d want 5", level); end
      req_valid = 4'b1000; req_data = 32'hA5_00_00_00;
      fifo_pop = 1'b1;
      advance();
      fifo_pop = 1'b0; req_valid = '0;
      checks++; if (obs_ready !== 4'b1000) begin errors++; $display("FAIL sim_grant: got %b want 1000", obs_ready); end
      checks++; if (level !== LW'(5)) begin errors++; $display("FAIL sim_level: got %0d want 5", level); end
      checks++; if (fifo_push !== 1'b1 || fifo_data_in !== 8'hA5) begin errors++; $display("FAIL sim_data: got %b/%h want 1/a5", fifo_push, fifo_data_in); end
   endtask

   task automatic test_error();
      reset_dut();
      auto_flags = 1'b0;
      fifo_pop = 1'b1; fifo_empty = 1'b0; fifo_full = 1'b0;
      advance();
      fifo_pop = 1'b0; fifo_empty = 1'b1;
      checks++; if (err_count !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", err_count); end
      checks++; if (level !== '0) begin errors++; $display("FAIL err_level: got %0d want 0", level); end
      for (int c = 0; c < 3; c++) advance();
      checks++; if (err_count !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err_count); end
      reset_dut();
      checks++; if (err_count !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", err_count); end
   endtask

   task automatic test_random();
      reset_dut();
      for (int c = 0; c < 400; c++) begin
         req_valid = NREQ'($urandom);
         req_data  = $urandom;
         fifo_pop  = ($urandom_range(0, 2) == 0);
         if (c == 200) rst = 1'b1;
         advance();
         rst = 1'b0;
         checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready%0d: got %b want %b", c, obs_ready, exp_ready); end
         checks++; if (fifo_push !== m_push) begin errors++; $display("FAIL rnd_push%0d: got %b want %b", c, fifo_push, m_push); end
         checks++; if (fifo_data_in !== m_data) begin errors++; $display("FAIL rnd_data%0d: got %h want %h", c, fifo_data_in, m_data); end
         checks++; if (level !== LW'(m_level)) begin errors++; $display("FAIL rnd_level%0d: got %0d want %0d", c, level, m_level); end
         checks++; if (err_overflow !== m_erro || err_count !== m_errc) begin errors++; $display("FAIL rnd_err%0d: got %b%b want %b%b", c, err_overflow, err_count, m_erro, m_errc); end
      end
   endtask

   initial begin
      rst = 1'b1; req_valid = '0; req_data = '0;
      fifo_pop = 1'b0; fifo_empty = 1'b1; fifo_full = 1'b0;
      m_level = 0; m_last = NREQ - 1; m_push = 1'b0; m_data = '0;
      m_erro = 1'b0; m_errc = 1'b0; f_cnt = 0;
      test_reset();
      test_round_robin();
      test_full();
      test_pop_at_full();
      test_simultaneous();
      test_error();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
